// File: rtl/dmem_dp_ctrl.sv
// Dual-port RV32I data memory.
// Port A serves the core: byte/half/word stores and formatted loads with fault reporting.
// Port B is a word-wide strobed port for the DMA/H.264 engine.
// A zeroing FSM can clear every word after reset; all accesses are ignored while it runs.
module dmem_dp_ctrl #(
    parameter int RV32I_DMEM_DEPTH = 4,
    parameter bit CLEAR_ON_RESET   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        busy_o,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_w_i,
    output logic [31:0] data_r_o,
    output logic        data_valid_o,
    output logic        fault_o,
    input  logic        s_axi_we_i,
    input  logic        s_axi_re_i,
    input  logic [3:0]  s_axi_wstrb_i,
    input  logic [31:0] s_axi_addr_i,
    input  logic [31:0] s_axi_data_i,
    output logic [31:0] s_axi_data_o,
    output logic        s_axi_rvalid_o
);
    localparam int          N     = RV32I_DMEM_DEPTH * 256;
    localparam int          AW    = $clog2(N);
    localparam logic [31:0] LIMIT = 32'(4 * N);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    logic [31:0] mem [N];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clr_we;

    logic          ld_vld_q, ld_vld_d;
    logic          ld_flt_q, ld_flt_d;
    logic [2:0]    ld_f3_q, ld_f3_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic          fault_q, fault_d;
    logic [31:0]   a_hold_q, a_hold_d;
    logic          b_vld_q, b_vld_d;
    logic          b_oor_q, b_oor_d;
    logic [31:0]   b_hold_q, b_hold_d;
    logic [31:0]   rd_a_q, rd_b_q;

    logic          run;
    logic          a_oor, b_oor;
    logic [1:0]    a_off;
    logic [AW-1:0] a_idx, b_idx;
    logic          st_ok, ld_ok;
    logic [3:0]    st_be, core_be, b_be;
    logic [31:0]   st_data;
    logic          ld_go;
    logic [31:0]   a_fmt, b_word;
    logic [7:0]    a_byte;
    logic [15:0]   a_half;
    logic          unused_ok;

    // Word address low bits of port B carry no information.
    assign unused_ok = ^s_axi_addr_i[1:0];

    assign run   = (state_q == ST_RUN);
    assign a_off = addr_i[1:0];
    assign a_idx = addr_i[AW+1:2];
    assign b_idx = s_axi_addr_i[AW+1:2];
    assign a_oor = (addr_i >= LIMIT);
    assign b_oor = (s_axi_addr_i >= LIMIT);

    // Zeroing FSM: walk every word once, then open the memory to both ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic for the zeroing FSM.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(N - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Core access decode: lane enables, replicated store data, legality.
    always_comb begin
        st_ok   = 1'b0;
        st_be   = 4'b0000;
        st_data = data_w_i;
        ld_ok   = 1'b0;
        case (funct3_i)
            3'b000: begin
                st_ok   = 1'b1;
                st_be   = 4'b0001 << a_off;
                st_data = {4{data_w_i[7:0]}};
            end
            3'b001: begin
                st_ok   = ~a_off[0];
                st_be   = a_off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{data_w_i[15:0]}};
            end
            3'b010: begin
                st_ok   = (a_off == 2'b00);
                st_be   = 4'b1111;
            end
            default: ;
        endcase
        case (funct3_i)
            3'b000, 3'b100: ld_ok = 1'b1;
            3'b001, 3'b101: ld_ok = ~a_off[0];
            3'b010:         ld_ok = (a_off == 2'b00);
            default:        ld_ok = 1'b0;
        endcase
    end

    assign core_be = (run && mem_we_i && st_ok && !a_oor) ? st_be : 4'b0000;
    assign b_be    = (run && s_axi_we_i && !b_oor) ? s_axi_wstrb_i : 4'b0000;
    assign ld_go   = run && mem_re_i && !mem_we_i;

    // RAM array: clear writes, then port B lanes, then core lanes so the core
    // wins any shared byte. Reads sample old contents (read-first).
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_cnt_q] <= 32'h0;
        for (int l = 0; l < 4; l++)
            if (b_be[l]) mem[b_idx][8*l +: 8] <= s_axi_data_i[8*l +: 8];
        for (int l = 0; l < 4; l++)
            if (core_be[l]) mem[a_idx][8*l +: 8] <= st_data[8*l +: 8];
        rd_a_q <= mem[a_idx];
        rd_b_q <= mem[b_idx];
    end

    // Load formatting from the registered word; faulting loads return zero.
    always_comb begin
        a_byte = rd_a_q[8*ld_off_q +: 8];
        a_half = ld_off_q[1] ? rd_a_q[31:16] : rd_a_q[15:0];
        case (ld_f3_q)
            3'b000:  a_fmt = {{24{a_byte[7]}}, a_byte};
            3'b100:  a_fmt = {24'h0, a_byte};
            3'b001:  a_fmt = {{16{a_half[15]}}, a_half};
            3'b101:  a_fmt = {16'h0, a_half};
            3'b010:  a_fmt = rd_a_q;
            default: a_fmt = 32'h0;
        endcase
        if (ld_flt_q) a_fmt = 32'h0;
        b_word = b_oor_q ? 32'h0 : rd_b_q;
    end

    // Response pipeline next-state: valid strobes, faults, held read data.
    always_comb begin
        ld_vld_d = ld_go;
        ld_flt_d = ld_go && (!ld_ok || a_oor);
        ld_f3_d  = funct3_i;
        ld_off_d = a_off;
        fault_d  = (ld_go && (!ld_ok || a_oor)) ||
                   (run && mem_we_i && (!st_ok || a_oor));
        a_hold_d = ld_vld_q ? a_fmt : a_hold_q;
        b_vld_d  = run && s_axi_re_i;
        b_oor_d  = b_oor;
        b_hold_d = b_vld_q ? b_word : b_hold_q;
    end

    // Response pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_vld_q <= 1'b0;
            ld_flt_q <= 1'b0;
            ld_f3_q  <= 3'b000;
            ld_off_q <= 2'b00;
            fault_q  <= 1'b0;
            a_hold_q <= 32'h0;
            b_vld_q  <= 1'b0;
            b_oor_q  <= 1'b0;
            b_hold_q <= 32'h0;
        end else begin
            ld_vld_q <= ld_vld_d;
            ld_flt_q <= ld_flt_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
            fault_q  <= fault_d;
            a_hold_q <= a_hold_d;
            b_vld_q  <= b_vld_d;
            b_oor_q  <= b_oor_d;
            b_hold_q <= b_hold_d;
        end
    end

    assign busy_o         = (state_q == ST_CLEAR);
    assign data_valid_o   = ld_vld_q;
    assign data_r_o       = ld_vld_q ? a_fmt : a_hold_q;
    assign fault_o        = fault_q;
    assign s_axi_rvalid_o = b_vld_q;
    assign s_axi_data_o   = b_vld_q ? b_word : b_hold_q;

endmodule

// File: tb/tb_dmem_dp_ctrl.sv
// Scoreboard bench for dmem_dp_ctrl (DEPTH=1 -> 256 words, clear on reset).
module tb_dmem_dp_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy_o;
    logic        mem_we_i = 0, mem_re_i = 0;
    logic [2:0]  funct3_i = 0;
    logic [31:0] addr_i = 0, data_w_i = 0;
    logic [31:0] data_r_o;
    logic        data_valid_o, fault_o;
    logic        s_axi_we_i = 0, s_axi_re_i = 0;
    logic [3:0]  s_axi_wstrb_i = 0;
    logic [31:0] s_axi_addr_i = 0, s_axi_data_i = 0;
    logic [31:0] s_axi_data_o;
    logic        s_axi_rvalid_o;

    dmem_dp_ctrl #(.RV32I_DMEM_DEPTH(1), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .busy_o(busy_o),
        .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .data_w_i(data_w_i), .data_r_o(data_r_o),
        .data_valid_o(data_valid_o), .fault_o(fault_o),
        .s_axi_we_i(s_axi_we_i), .s_axi_re_i(s_axi_re_i),
        .s_axi_wstrb_i(s_axi_wstrb_i), .s_axi_addr_i(s_axi_addr_i),
        .s_axi_data_i(s_axi_data_i), .s_axi_data_o(s_axi_data_o),
        .s_axi_rvalid_o(s_axi_rvalid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        flt;
    } core_exp_t;

    core_exp_t   core_q[$];
    logic [31:0] b_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every core/B response pops one expectation.
    always @(negedge clk) begin
        if (data_valid_o || fault_o) begin
            if (core_q.size() == 0) begin
                chk("core_unexpected_resp", {30'h0, data_valid_o, fault_o}, 32'h0);
            end else begin
                core_exp_t e;
                e = core_q.pop_front();
                chk("core_valid", {31'h0, data_valid_o}, {31'h0, e.vld});
                chk("core_fault", {31'h0, fault_o}, {31'h0, e.flt});
                if (e.vld) chk("core_data", data_r_o, e.data);
            end
        end
        if (s_axi_rvalid_o) begin
            if (b_q.size() == 0) chk("b_unexpected_rvalid", 32'h1, 32'h0);
            else                 chk("b_data", s_axi_data_o, b_q.pop_front());
        end
    end

    task automatic push_core(input logic v, input logic [31:0] d, input logic f);
        core_exp_t e;
        e.vld = v; e.data = d; e.flt = f;
        core_q.push_back(e);
    endtask

    // Drive all inputs for exactly one cycle.
    task automatic drv(input logic cwe, input logic cre, input logic [2:0] f3,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic bwe, input logic bre, input logic [3:0] bs,
                       input logic [31:0] ba, input logic [31:0] bd);
        @(posedge clk); #1;
        mem_we_i = cwe; mem_re_i = cre; funct3_i = f3; addr_i = ca; data_w_i = cd;
        s_axi_we_i = bwe; s_axi_re_i = bre; s_axi_wstrb_i = bs;
        s_axi_addr_i = ba; s_axi_data_i = bd;
    endtask

    task automatic core(input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        drv(we, re, f3, a, d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic bop(input logic we, input logic re, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d);
        drv(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, we, re, s, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bop(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Count negedges with busy_o high; optionally inject ignored requests mid-clear.
    task automatic count_busy(input logic inject, output int cnt);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (inject && i == 50) begin
                s_axi_we_i = 1; s_axi_re_i = 1; s_axi_wstrb_i = 4'hF;
                s_axi_addr_i = 32'h0; s_axi_data_i = 32'hFFFF_FFFF;
                mem_we_i = 0; mem_re_i = 1; funct3_i = 3'b011; addr_i = 32'h0;
            end
            if (inject && i == 51) begin
                s_axi_we_i = 0; s_axi_re_i = 0; mem_re_i = 0;
                mem_we_i = 1; funct3_i = 3'b001; addr_i = 32'h1;
            end
            if (inject && i == 52) mem_we_i = 0;
            if (!busy_o) break;
            cnt++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy_o}, 32'h1);
        chk("rst_data_r", data_r_o, 32'h0);
        chk("rst_valid", {30'h0, data_valid_o, fault_o}, 32'h0);
        chk("rst_b_data", s_axi_data_o, 32'h0);
        chk("rst_b_rvalid", {31'h0, s_axi_rvalid_o}, 32'h0);
        rst_n = 1'b1;
        // Interrupt the clear at count 100 and confirm a full restart.
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midclear_rst_busy", {31'h0, busy_o}, 32'h1);
        @(posedge clk); #1 rst_n = 1'b1;
        count_busy(1'b1, cnt);
        chk("busy_cycles", 32'(cnt), 32'd256);

        bop(0, 1, 4'h0, 32'h3FC, 0);                   b_q.push_back(32'h0);
        core(1, 0, 3'b010, 32'h10, 32'hDEADBEEF);
        core(0, 1, 3'b000, 32'h13, 0);                 push_core(1, 32'hFFFFFFDE, 0);
        core(0, 1, 3'b101, 32'h12, 0);                 push_core(1, 32'h0000DEAD, 0);
        core(0, 1, 3'b010, 32'h10, 0);                 push_core(1, 32'hDEADBEEF, 0);
        core(0, 1, 3'b001, 32'h10, 0);                 push_core(1, 32'hFFFFBEEF, 0);
        core(0, 1, 3'b100, 32'h11, 0);                 push_core(1, 32'h000000BE, 0);

        core(1, 0, 3'b010, 32'h20, 32'h12345678);
        core(1, 0, 3'b001, 32'h21, 32'h0000FFFF);      push_core(0, 32'h0, 1);
        core(0, 1, 3'b010, 32'h20, 0);                 push_core(1, 32'h12345678, 0);
        core(0, 1, 3'b010, 32'h22, 0);                 push_core(1, 32'h0, 1);
        core(0, 1, 3'b011, 32'h20, 0);                 push_core(1, 32'h0, 1);
        core(0, 1, 3'b110, 32'h20, 0);                 push_core(1, 32'h0, 1);
        core(0, 1, 3'b010, 32'h400, 0);                push_core(1, 32'h0, 1);
        core(1, 0, 3'b010, 32'h400, 32'hFFFFFFFF);     push_core(0, 32'h0, 1);
        core(1, 0, 3'b011, 32'h30, 32'h1);             push_core(0, 32'h0, 1);

        // Same-cycle write collision: core byte lane wins.
        drv(1, 0, 3'b000, 32'h40, 32'hAA, 1, 0, 4'hF, 32'h40, 32'h11223344);
        core(0, 1, 3'b010, 32'h40, 0);                 push_core(1, 32'h112233AA, 0);
        bop(0, 1, 4'h0, 32'h40, 0);                    b_q.push_back(32'h112233AA);
        // B read vs core write: read-first.
        drv(1, 0, 3'b010, 32'h40, 32'h5, 0, 1, 4'h0, 32'h40, 0);
        b_q.push_back(32'h112233AA);
        bop(0, 1, 4'h0, 32'h40, 0);                    b_q.push_back(32'h5);

        bop(1, 0, 4'b0101, 32'h50, 32'hCAFEF00D);
        bop(0, 1, 4'h0, 32'h50, 0);                    b_q.push_back(32'h00FE000D);
        core(0, 1, 3'b100, 32'h52, 0);                 push_core(1, 32'h000000FE, 0);
        bop(0, 1, 4'h0, 32'h400, 0);                   b_q.push_back(32'h0);
        // Core read vs B write: read-first.
        drv(0, 1, 3'b010, 32'h60, 0, 1, 0, 4'hF, 32'h60, 32'h77);
        push_core(1, 32'h0, 0);
        core(0, 1, 3'b010, 32'h60, 0);                 push_core(1, 32'h00000077, 0);
        // B write and read in one cycle.
        bop(1, 1, 4'hF, 32'h70, 32'h99);               b_q.push_back(32'h0);
        bop(0, 1, 4'h0, 32'h70, 0);                    b_q.push_back(32'h99);
        idle(3);
        #1 chk("b_hold", s_axi_data_o, 32'h99);
        // Core store+load in one cycle: store only, no response.
        core(1, 1, 3'b010, 32'h80, 32'hABCD);
        core(0, 1, 3'b010, 32'h80, 0);                 push_core(1, 32'h0000ABCD, 0);
        idle(3);
        #1 chk("core_hold", data_r_o, 32'h0000ABCD);
        // Out-of-range B write aliasing word 0 is dropped; word 0 stayed clear.
        bop(1, 0, 4'hF, 32'h400, 32'hFFFFFFFF);
        bop(0, 1, 4'h0, 32'h0, 0);                     b_q.push_back(32'h0);
        core(0, 1, 3'b010, 32'h0, 0);                  push_core(1, 32'h0, 0);
        idle(5);
        chk("core_q_drained", 32'(core_q.size()), 32'h0);
        chk("b_q_drained", 32'(b_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
